// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INHIBIT   = 4'd1,
    ST_REQUEST   = 4'd2,
    ST_RELEASE   = 4'd3,
    ST_WAIT_LOW  = 4'd4,
    ST_WAIT_HIGH = 4'd5,
    ST_ACK_LOW   = 4'd6,
    ST_ACK_HIGH  = 4'd7,
    ST_DONE      = 4'd8,
    ST_FAIL      = 4'd9
  } ps2_state_t;

  // Clock debouncer: history depth and number of newest samples that must agree.
  localparam int DEB_LEN   = 8;
  localparam int DEB_MATCH = 5;

  // Start + 8 data + parity + stop on the wire; the host shifts all but the start bit.
  localparam int FRAME_WIRE_BITS = 11;
  localparam int FRAME_HOST_BITS = 10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 pads and classifies the clock line with a
// shift-register debouncer so short glitches never look like device edges.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_high,
  output logic clk_low,
  output logic data_sync
);

  logic               clk_s1_q, clk_s2_q;
  logic               data_s1_q, data_s2_q;
  logic [DEB_LEN-1:0] deb_q;
  logic               high_q;
  logic               all_one, all_zero;

  // Two-stage synchronizers; the idle bus is high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= clk_in;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= data_in;
      data_s2_q <= data_s1_q;
    end
  end

  // Clock history shift register plus the held classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= '1;
      high_q <= 1'b1;
    end else begin
      deb_q  <= (deb_q << 1) | {{(DEB_LEN-1){1'b0}}, clk_s2_q};
      high_q <= clk_high;
    end
  end

  // A new level is accepted only when the newest samples all agree.
  always_comb begin
    all_one  = &deb_q[DEB_MATCH-1:0];
    all_zero = ~|deb_q[DEB_MATCH-1:0];
    clk_high = all_one | (high_q & ~all_zero);
    clk_low  = ~clk_high;
  end

  assign data_sync = data_s2_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift the frame
// on device clock edges, then check the device acknowledge.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | lines released, waiting for start
// INHIBIT    | clock held low to abort any device transfer
// REQUEST    | clock and data held low (start bit)
// RELEASE    | clock released, data low, wait for the device to idle high
// WAIT_LOW   | wait for device clock low, then present next bit
// WAIT_HIGH  | wait for device clock high
// ACK_LOW    | data released, sample the acknowledge bit
// ACK_HIGH   | wait for clock and data to return high
// DONE       | one-cycle done pulse
// FAIL       | one-cycle error pulse (timeout or missing ack)
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int REQUEST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 180000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, REQUEST_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQUEST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [FRAME_HOST_BITS-1:0] frame_q, frame_d;
  logic [3:0]                 idx_q, idx_d;
  logic                       clk_oe_q, clk_oe_d;
  logic                       data_oe_q, data_oe_d;
  logic                       clk_high, clk_low, data_sync;
  logic                       timeout;

  ps2_line_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_high  (clk_high),
    .clk_low   (clk_low),
    .data_sync (data_sync)
  );

  // State, frame, bit index and registered pad enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Phase counter: restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (cnt_q == TMO_LAST);

  // Next-state logic; pad enables are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    unique case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (start) begin
          frame_d  = {1'b1, ~^data, data};
          idx_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
        if (cnt_q == REQ_LAST) begin
          clk_oe_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        data_oe_d = 1'b1;
        if (clk_high) begin
          state_d = ST_WAIT_LOW;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          state_d   = ST_FAIL;
        end
      end
      ST_WAIT_LOW: begin
        if (clk_low) begin
          if (idx_q < 4'(FRAME_HOST_BITS)) begin
            data_oe_d = ~frame_q[idx_q];
            idx_d     = idx_q + 4'd1;
            state_d   = ST_WAIT_HIGH;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK_LOW;
          end
        end else if (timeout) begin
          data_oe_d = 1'b0;
          state_d   = ST_FAIL;
        end
      end
      ST_WAIT_HIGH: begin
        if (clk_high) begin
          state_d = ST_WAIT_LOW;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          state_d   = ST_FAIL;
        end
      end
      ST_ACK_LOW: begin
        data_oe_d = 1'b0;
        state_d   = data_sync ? ST_FAIL : ST_ACK_HIGH;
      end
      ST_ACK_HIGH: begin
        data_oe_d = 1'b0;
        if (clk_high && data_sync) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_FAIL;
        end
      end
      ST_DONE: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      ST_FAIL: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_FAIL);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a behavioural PS/2 device clocks frames out of the
// DUT, and a scoreboard of expected frames/outcomes is checked as each ends.
`timescale 1ns/1ps
module tb_ps2_transmitter;

  localparam int INH  = 60;
  localparam int REQ  = 16;
  localparam int TMO  = 2000;
  localparam int HALF = 40;
  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] byte_v;
    logic       par;
    logic       ack;
  } exp_t;
  exp_t exp_q[$];

  logic [11:0] dev_bits;
  logic        m_done, m_err, m_busy_after, m_oe_after, m_pulse_after;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #500 clk = ~clk;

  ps2_transmitter #(
    .INHIBIT_CYCLES (INH),
    .REQUEST_CYCLES (REQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic ref_par(input logic [7:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (b[i]) n++;
    return (n % 2 == 0);
  endfunction

  // Device model: checks inhibit/request timing, then clocks 11 pulses and
  // samples data on each rising edge. abort_at>0 stops after that rising edge.
  task automatic dev_run(input bit ack, input bit glitch, input int abort_at);
    int c;
    dev_bits = '0;
    c = 0;
    while (!ps2_data_oe && c < BUDGET) begin @(negedge clk); c++; end
    chk("inhibit_len", c, INH);
    while (ps2_clk_oe && c < BUDGET) begin @(negedge clk); c++; end
    chk("request_len", c, INH + REQ);
    if (c >= BUDGET) return;
    dev_bits[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_bits[k] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (k == abort_at) return;
      for (int j = 0; j < HALF; j++) begin
        if (k == 10 && ack && j == HALF / 2) dev_data_low = 1'b1;
        if (k == 11 && j == 5) dev_data_low = 1'b0;
        if (glitch && k < 10) dev_clk_low = (j >= 10 && j < 13);
        @(negedge clk);
      end
    end
  endtask

  // Waits for the done/error pulse and records the following cycle.
  task automatic mon();
    int c;
    c = 0;
    while (!done && !error && c < BUDGET) begin @(negedge clk); c++; end
    if (c >= BUDGET) chk("pulse_wait_expired", 32'(c), 32'(BUDGET + 1));
    m_done = done;
    m_err  = error;
    @(negedge clk);
    m_busy_after  = busy;
    m_oe_after    = ps2_clk_oe | ps2_data_oe;
    m_pulse_after = done | error;
  endtask

  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_clk_oe", ps2_clk_oe, 1);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit glitch);
    exp_t e;
    e.byte_v = b;
    e.par    = ref_par(b);
    e.ack    = ack;
    exp_q.push_back(e);
    send_start(b);
    fork
      dev_run(ack, glitch, 0);
      mon();
    join
    e = exp_q.pop_front();
    chk("start_bit", dev_bits[0], 0);
    chk("data_byte", dev_bits[8:1], e.byte_v);
    chk("parity", dev_bits[9], e.par);
    chk("stop_bit", dev_bits[10], 1);
    chk("done_seen", m_done, e.ack);
    chk("error_seen", m_err, !e.ack);
    chk("pulse_one_cycle", m_pulse_after, 0);
    chk("busy_after", m_busy_after, 0);
    chk("oe_after", m_oe_after, 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    xfer(8'hED, 1'b1, 1'b0);
    xfer(8'hFF, 1'b1, 1'b0);
    xfer(8'h00, 1'b1, 1'b0);
    xfer(8'h01, 1'b1, 1'b0);

    // Device holds the clock low forever after release.
    dev_clk_low = 1'b1;
    send_start(8'h3C);
    c = 0;
    while (ps2_clk_oe && c < BUDGET) begin @(negedge clk); c++; end
    c = 0;
    while (!error && c < TMO + 500) begin @(negedge clk); c++; end
    chk("timeout_len", c, TMO);
    chk("timeout_done", done, 0);
    chk("timeout_oe", ps2_clk_oe | ps2_data_oe, 0);
    @(negedge clk);
    chk("timeout_busy_after", busy, 0);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);

    xfer(8'h55, 1'b0, 1'b0);
    xfer(8'h96, 1'b1, 1'b1);

    // Reset mid-frame after bit 4 (bit 4 of 0x0F is 0, so data is pulled low).
    send_start(8'h0F);
    dev_run(1'b1, 1'b0, 5);
    chk("abort_bits", dev_bits[5:1], 5'h0F);
    chk("pre_rst_data_oe", ps2_data_oe, 1);
    #200;
    rst_n = 1'b0;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    chk("abort_pulse", done | error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    xfer(8'hA5, 1'b1, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter: sends one command byte (e.g. keyboard LED set, reset 0xFF) to a PS/2 device. It runs the inhibit/request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clock edges, and checks the device acknowledge. It sits beside `ps2_receiver` on the same open-drain `ps2_clk`/`ps2_data` pads. The pads' tristate buffers are outside this block.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 1200: clock-low inhibit duration before request (100 µs at 12 MHz).
- `REQUEST_CYCLES`, default 16: cycles both lines are held low before the clock is released.
- `TIMEOUT_CYCLES`, default 180000: maximum wait, in cycles, for any expected device clock level (15 ms at 12 MHz).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in 8: byte to send; sampled in the cycle `start` is accepted.
- `start` in 1: request to transmit; ignored while `busy`=1.
- `busy` out 1: high from the cycle after acceptance until the `done`/`error` cycle, inclusive.
- `done` out 1: one-cycle pulse; the device acknowledged.
- `error` out 1: one-cycle pulse; there was a timeout or the ACK was missing.
- `ps2_clk_in` in 1: raw pad value of the PS/2 clock.
- `ps2_data_in` in 1: raw pad value of the PS/2 data.
- `ps2_clk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data line low; 0 releases it.

## Operation
- Line filtering:
  - `ps2_clk_in` goes through a 2-FF synchronizer, then an 8-bit shift debouncer.
  - The filtered clock is *high* when the newest 5 samples are all 1 and *low* when they are all 0. Otherwise it holds its previous classification.
  - `ps2_data_in` goes through a 2-FF synchronizer only.
- Frame register: 10 bits {stop=1, parity=~^data, data[7:0]}, shifted out LSB first. The start bit (0) is driven during REQUEST.
- State machine (a phase counter is cleared on every state change):
  - IDLE: both oe=0. If `start`=1, capture the frame, set bit index to 0 → INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles → REQUEST.
  - REQUEST: clk_oe=1, data_oe=1 for REQUEST_CYCLES cycles → RELEASE.
  - RELEASE: clk_oe=0, data_oe=1. Wait for filtered clock high → WAIT_LOW.
  - WAIT_LOW: on filtered clock low:
    - if index < 10, set data_oe = ~frame[index], increment index → WAIT_HIGH;
    - if index == 10, data_oe=0 and ACK_LOW.
  - WAIT_HIGH: on filtered clock high → WAIT_LOW.
  - ACK_LOW: sample synchronized data in the same cycle clock low was detected:
    - if data=0 → ACK_HIGH;
    - if data=1 → FAIL.
  - ACK_HIGH: wait for filtered clock high and data high → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
  - FAIL: `error`=1 for one cycle, both oe=0 → IDLE.
- Timeout: in RELEASE, WAIT_LOW, WAIT_HIGH and ACK_HIGH, if the phase counter reaches TIMEOUT_CYCLES, go to FAIL.
- `done` and `error` are never asserted in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0. State is IDLE, the debouncer is preloaded with 0xFF (line idle high).
- Reset asserted mid-frame: both lines are released immediately (asynchronous). No `done` or `error` pulse is issued.
- Acceptance:
  - `start` is accepted in the cycle it is seen in IDLE.
  - From that edge: `busy`=1 and `ps2_clk_oe`=1 on the next edge.
  - `ps2_data_oe` rises INHIBIT_CYCLES cycles later.
  - `ps2_clk_oe` falls INHIBIT_CYCLES+REQUEST_CYCLES cycles after `ps2_clk_oe` rose.
- Data changes only after a detected clock low. Filter latency is 2 sync + 5 debounce cycles, well inside the ≥30 µs device low phase.
- `start` may be asserted again in the same cycle `busy` falls to 0. That is the cycle after the `done`/`error` pulse.
- Counter width: `$clog2(max(INHIBIT_CYCLES, REQUEST_CYCLES, TIMEOUT_CYCLES)+1)`. The counter saturates; it never wraps.

## Structure
- Shared package `ps2_pkg`:
  - state encoding;
  - debounce length (8) and match width (5);
  - frame length constants (11 on the wire, 10 shifted by the host).
- Sub-module `ps2_line_filter`: the synchronizer plus debouncer, with outputs `clk_high`, `clk_low`, `data_sync`. The receiver is to reuse it.
- The top-level holds the FSM, phase counter, frame register and bit index.

## Test plan
- Byte 0xED: a device model clocks at 12.5 kHz and ACKs.
  - The model captures data 0xED, parity 1, stop 1.
  - `done` pulses once, `busy` falls the next cycle, both oe=0.
- Byte 0xFF: parity bit is 1; byte 0x00: parity bit is 1; byte 0x01: parity bit is 0. Each completes with `done`.
- The device never clocks after RELEASE: `error` pulses exactly TIMEOUT_CYCLES cycles after RELEASE is entered, and both lines are released.
- The device leaves data high on the 11th clock (no ACK): `error` pulses and `done` stays 0.
- Clock glitch: 3-cycle low pulses on `ps2_clk_in` are injected between real edges. Frame content is unchanged and `done` pulses.
- Mid-frame: `rst_n` is pulsed low after bit 4; both oe drop in the same cycle. Then `start` is asserted again and a complete transfer with `done` follows.
